// File: rtl/cache_pkg.sv
// Shared definitions for the blk_cache slice: controller state encoding,
// line metadata bit positions and address-field width helpers.
package cache_pkg;

    // Controller states; also driven out on the fsm_state debug port.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_ALLOCATE  = 2'd3
    } cache_state_t;

    // Line metadata word layout: {tag, D, V}.
    localparam int V_BIT      = 0;
    localparam int D_BIT      = 1;
    localparam int META_FLAGS = 2;

    // Bits selecting a byte within a word.
    function automatic int byte_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Bits selecting a word within a line.
    function automatic int word_off_w(input int words);
        return $clog2(words);
    endfunction

    // Whatever is left of the address above index and offsets.
    function automatic int tag_w(input int addr_w, input int index_w,
                                 input int words, input int data_w);
        return addr_w - index_w - word_off_w(words) - byte_off_w(data_w);
    endfunction

endpackage

// File: rtl/cache_data_array.sv
// Line data storage for blk_cache: WORDS words per line, 2**INDEX_W lines,
// one byte-strobed write port and one combinational read port.
module cache_data_array
    import cache_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 4,
    parameter int WORDS   = 4
) (
    input  logic                                  clk,
    input  logic                                  we,
    input  logic [INDEX_W+word_off_w(WORDS)-1:0]  waddr,
    input  logic [DATA_W-1:0]                     wdata,
    input  logic [DATA_W/8-1:0]                   wstrb,
    input  logic [INDEX_W+word_off_w(WORDS)-1:0]  raddr,
    output logic [DATA_W-1:0]                     rdata
);

    localparam int AW     = INDEX_W + word_off_w(WORDS);
    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [2**AW];

    // Byte-granular write; storage is not reset, validity lives in the tags.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/blk_cache.sv
// blk_cache: direct-mapped, write-back, write-allocate cache controller.
// Optional macro BLK_CACHE_PERF_EN adds hit_cnt / miss_cnt counter outputs.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high; an offered mem beat keeps valid/addr/wr/wdata stable
// until it is taken, and the cpu side only accepts while in IDLE.
module blk_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 4,
    parameter int WORDS   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req_valid,
    output logic                cpu_req_ready,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    input  logic                cpu_req_wr,
    input  logic [DATA_W-1:0]   cpu_req_wdata,
    input  logic [DATA_W/8-1:0] cpu_req_wstrb,
    output logic                cpu_resp_valid,
    output logic [DATA_W-1:0]   cpu_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    input  logic [DATA_W-1:0]   mem_resp_data,
`ifdef BLK_CACHE_PERF_EN
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt,
`endif
    output cache_state_t        fsm_state
);

    localparam int BYTE_W = byte_off_w(DATA_W);
    localparam int WOFF_W = word_off_w(WORDS);
    localparam int TAG_W  = tag_w(ADDR_W, INDEX_W, WORDS, DATA_W);
    localparam int LINES  = 2**INDEX_W;
    localparam int STRB_W = DATA_W / 8;
    localparam int META_W = TAG_W + META_FLAGS;

    cache_state_t         state;
    logic [META_W-1:0]    meta [LINES];

    logic [TAG_W-1:0]     req_tag;
    logic [INDEX_W-1:0]   req_index;
    logic [WOFF_W-1:0]    req_word;
    logic                 req_wr;
    logic [DATA_W-1:0]    req_wdata;
    logic [STRB_W-1:0]    req_wstrb;
    logic [WOFF_W-1:0]    beat;

    logic [META_W-1:0]    line_meta;
    logic                 line_valid;
    logic                 line_dirty;
    logic [TAG_W-1:0]     line_tag;
    logic                 hit;
    logic                 cmp_hit;
    logic                 last_beat;

    logic                        arr_we;
    logic [INDEX_W+WOFF_W-1:0]   arr_waddr;
    logic [DATA_W-1:0]           arr_wdata;
    logic [STRB_W-1:0]           arr_wstrb;
    logic [INDEX_W+WOFF_W-1:0]   arr_raddr;
    logic [DATA_W-1:0]           arr_rdata;
    logic [DATA_W-1:0]           merged;

    // Byte offset never matters: accesses are whole words with strobes.
    logic unused_byte_off;
    assign unused_byte_off = ^cpu_req_addr[BYTE_W-1:0];

    assign line_meta  = meta[req_index];
    assign line_valid = line_meta[V_BIT];
    assign line_dirty = line_meta[D_BIT];
    assign line_tag   = line_meta[META_W-1:META_FLAGS];
    assign hit        = line_valid && (line_tag == req_tag);
    assign cmp_hit    = (state == ST_COMPARE) && hit;
    assign last_beat  = (beat == WOFF_W'(WORDS - 1));

    // Writeback streams the victim line out by beat; otherwise read the requested word.
    assign arr_raddr = (state == ST_WRITEBACK) ? {req_index, beat} : {req_index, req_word};

    // Fill beats write whole words; a write hit writes only the strobed bytes.
    assign arr_we    = (cmp_hit && req_wr) || ((state == ST_ALLOCATE) && mem_req_ready);
    assign arr_waddr = (state == ST_ALLOCATE) ? {req_index, beat} : {req_index, req_word};
    assign arr_wdata = (state == ST_ALLOCATE) ? mem_resp_data : req_wdata;
    assign arr_wstrb = (state == ST_ALLOCATE) ? {STRB_W{1'b1}} : req_wstrb;

    cache_data_array #(
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W),
        .WORDS   (WORDS)
    ) u_data (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .wstrb (arr_wstrb),
        .raddr (arr_raddr),
        .rdata (arr_rdata)
    );

    // Stored word with the request's strobed bytes laid over it.
    always_comb begin
        merged = arr_rdata;
        for (int b = 0; b < STRB_W; b++) begin
            if (req_wstrb[b]) begin
                merged[b*8 +: 8] = req_wdata[b*8 +: 8];
            end
        end
    end

    // Controller: request latch, beat counter and line metadata updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            beat      <= '0;
            req_tag   <= '0;
            req_index <= '0;
            req_word  <= '0;
            req_wr    <= 1'b0;
            req_wdata <= '0;
            req_wstrb <= '0;
            for (int i = 0; i < LINES; i++) begin
                meta[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req_valid) begin
                        req_tag   <= cpu_req_addr[ADDR_W-1 -: TAG_W];
                        req_index <= cpu_req_addr[BYTE_W+WOFF_W +: INDEX_W];
                        req_word  <= cpu_req_addr[BYTE_W +: WOFF_W];
                        req_wr    <= cpu_req_wr;
                        req_wdata <= cpu_req_wdata;
                        req_wstrb <= cpu_req_wstrb;
                        state     <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (hit) begin
                        if (req_wr) begin
                            meta[req_index][D_BIT] <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else if (line_valid && line_dirty) begin
                        state <= ST_WRITEBACK;
                    end else begin
                        state <= ST_ALLOCATE;
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_req_ready) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            state <= ST_ALLOCATE;
                        end
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_req_ready) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            // Only a fully filled line becomes valid.
                            meta[req_index][META_W-1:META_FLAGS] <= req_tag;
                            meta[req_index][V_BIT]               <= 1'b1;
                            meta[req_index][D_BIT]               <= 1'b0;
                            state                                <= ST_COMPARE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign fsm_state      = state;
    assign cpu_req_ready  = (state == ST_IDLE);
    assign cpu_resp_valid = cmp_hit;
    assign cpu_resp_data  = cmp_hit ? (req_wr ? merged : arr_rdata) : '0;

    assign mem_req_valid = (state == ST_WRITEBACK) || (state == ST_ALLOCATE);
    assign mem_req_wr    = (state == ST_WRITEBACK);
    assign mem_req_wdata = (state == ST_WRITEBACK) ? arr_rdata : '0;
    assign mem_req_addr  = (state == ST_WRITEBACK) ? {line_tag, req_index, beat, {BYTE_W{1'b0}}} :
                           (state == ST_ALLOCATE)  ? {req_tag,  req_index, beat, {BYTE_W{1'b0}}} :
                                                     '0;

`ifdef BLK_CACHE_PERF_EN
    logic first_cmp;

    // Hits only count on the compare straight after accept; the post-fill compare is not a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            first_cmp <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && cpu_req_valid) begin
                first_cmp <= 1'b1;
            end
            if (state == ST_COMPARE) begin
                first_cmp <= 1'b0;
                if (hit) begin
                    if (first_cmp) begin
                        hit_cnt <= hit_cnt + 32'd1;
                    end
                end else begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/blk_cache.md
BLK_CACHE -- requirements
Module: blk_cache

Interface
REQ-001 Parameter ADDR_W, 32, CPU/memory byte-address width.
REQ-002 Parameter DATA_W, 32, word width; multiple of 8.
REQ-003 Parameter INDEX_W, 4, line-index bits; 2**INDEX_W lines.
REQ-004 Parameter WORDS, 4, words per line; power of two, >=2.
REQ-005 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 cpu_req_valid  in  1  request present; cpu_req_ready  out  1  request accepted when both high.
REQ-007 cpu_req_addr  in  ADDR_W  byte address; cpu_req_wr  in  1  1=write, 0=read.
REQ-008 cpu_req_wdata  in  DATA_W  write data; cpu_req_wstrb  in  DATA_W/8  byte enables.
REQ-009 cpu_resp_valid  out  1  one-cycle completion pulse; cpu_resp_data  out  DATA_W  read word, or merged word on write.
REQ-010 mem_req_valid  out  1; mem_req_ready  in  1; beat completes when both high.
REQ-011 mem_req_addr  out  ADDR_W  word-aligned beat address; mem_req_wr  out  1; mem_req_wdata  out  DATA_W.
REQ-012 mem_resp_data  in  DATA_W  read data, valid in the cycle the read beat completes.

Function
REQ-013 Direct-mapped, write-back, write-allocate; address split {tag, index, word offset (log2 WORDS), byte offset (log2 DATA_W/8)}.
REQ-014 Per line: V bit, D bit, tag, WORDS data words.
REQ-015 FSM states IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-016 IDLE: cpu_req_ready=1; on accept, latch addr/wr/wdata/wstrb, go COMPARE; ready=0 in all other states.
REQ-017 COMPARE hit (V and tag equal): cpu_resp_valid=1 in that cycle, return to IDLE; accept-to-response latency 1 cycle.
REQ-018 Write hit: merge bytes where wstrb=1, set D; cpu_resp_data = merged word.
REQ-019 COMPARE miss with V&D: go WRITEBACK; miss otherwise: go ALLOCATE.
REQ-020 WRITEBACK: WORDS write beats, address {stored tag, index, beat, 0}, beat 0..WORDS-1 ascending; then ALLOCATE.
REQ-021 ALLOCATE: WORDS read beats, address {req tag, index, beat, 0}; each beat writes word; after last, set V=1, D=0, tag; go COMPARE (guaranteed hit).
REQ-022 mem_req_valid, addr, wr, wdata held stable while mem_req_ready=0; beat counter wraps to 0 after last beat.
REQ-023 mem_req_valid=0 in IDLE and COMPARE; mem_req_ready ignored there.
REQ-024 cpu_req_* inputs ignored outside IDLE.

Reset
REQ-025 rst: state IDLE, all V and D cleared, beat counter 0, all outputs 0 next cycle except cpu_req_ready=1.
REQ-026 rst mid-WRITEBACK/ALLOCATE abandons the burst; dirty data is lost; no partial line marked valid.

Configuration
REQ-027 Macro BLK_CACHE_PERF_EN defined: outputs hit_cnt, miss_cnt (32 bits each) count COMPARE hits on first compare and misses, wrap at 2**32, cleared by rst.
REQ-028 Without BLK_CACHE_PERF_EN: ports and counters absent; behaviour otherwise identical.

Structure
REQ-029 Package cache_pkg: FSM state enum, tag/offset width functions, D/V bit positions.
REQ-030 Sub-module cache_data_array: WORDS x 2**INDEX_W word storage, one write port with byte strobes, one combinational read port.

Verification (default parameters; tag [31:8], index [7:4], word [3:2])
REQ-031 After rst, read 0x104 -> read beats 0x100,0x104,0x108,0x10C; resp_data = mem[0x104]; miss_cnt=1.
REQ-032 Then read 0x108 -> no mem beats; resp_valid 1 cycle after accept; hit_cnt=1.
REQ-033 Write 0x104, wdata 0xDEADBEEF, wstrb 4'b0011 -> no mem traffic; re-read 0x104 returns {mem[0x104][31:16], 16'hBEEF}.
REQ-034 Read 0x2104 -> write beats 0x100..0x10C with merged data, then read beats 0x2100..0x210C; resp_data = mem[0x2104].
REQ-035 mem_req_ready held low 10 cycles in ALLOCATE beat 1 -> valid, addr 0x2104 stable throughout; burst completes normally.
REQ-036 rst during WRITEBACK beat 2 -> next cycle mem_req_valid=0, state IDLE; subsequent read 0x104 misses clean (no write beats).
